// File: rtl/aes_sched_pkg.sv
// Shared types and helpers for the S-box time-multiplexing scheduler.
//   state_e : scheduler FSM states
//   grant_e : which requester was served last (state datapath or key word)
//   beats() : number of beats needed to push a 16-byte state through nsbox lanes
package aes_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSubSt,
        StSubKw,
        StDoneSt,
        StDoneKw
    } state_e;

    typedef enum logic {
        GNT_ST,
        GNT_KW
    } grant_e;

    function automatic int unsigned beats(input int unsigned nsbox);
        return 16 / nsbox;
    endfunction

endpackage

// File: rtl/aes_sub_bytes.sv
// Single AES S-box lane: multiplicative inverse in GF(2^8) followed by the
// AES affine transform. Purely combinational.
//   din  : input byte
//   dout : substituted byte
module aes_sub_bytes (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 for x != 0, and maps 0 to 0 as AES requires.
    // Builds x^(2^k - 1) up to x^127, then one final squaring.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] y;
        y = x;
        for (int i = 0; i < 6; i++) begin
            y = gf_mul(gf_mul(y, y), x);
        end
        return gf_mul(y, y);
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

    always_comb begin
        dout = affine(gf_inv(din));
    end

endmodule

// File: rtl/aes_sbox_sched.sv
// Shares a bank of NSBOX S-box lanes between the round datapath (16-byte
// SubBytes, serialised over 16/NSBOX beats) and the key schedule (4-byte
// SubWord, one beat). Round-robin arbitration when both request together.
//   clk, rst_n          : clock, asynchronous active-low reset
//   st_valid/st_in      : state request and 128-bit state
//   st_ready            : state request may be accepted this cycle
//   st_done/st_out      : one-cycle completion pulse, substituted state
//   kw_valid/kw_in      : key-word request and 32-bit word
//   kw_ready            : key-word request may be accepted this cycle
//   kw_done/kw_out      : one-cycle completion pulse, substituted word
//   busy                : scheduler not idle
module aes_sbox_sched
    import aes_sched_pkg::*;
#(
    parameter int unsigned NSBOX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_valid,
    input  logic [127:0] st_in,
    output logic         st_ready,
    output logic         st_done,
    output logic [127:0] st_out,
    input  logic         kw_valid,
    input  logic [31:0]  kw_in,
    output logic         kw_ready,
    output logic         kw_done,
    output logic [31:0]  kw_out,
    output logic         busy
);

    localparam int unsigned NB = beats(NSBOX);
    localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

    if (NSBOX != 4 && NSBOX != 8 && NSBOX != 16) begin : g_bad_nsbox
        $error("aes_sbox_sched: NSBOX must be 4, 8 or 16");
    end

    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    grant_e         last_grant_q;
    logic [127:0]   st_buf_q;
    logic [31:0]    kw_buf_q;

    logic           both_valid;
    logic           st_acc;
    logic           kw_acc;
    logic [7:0]     lane_in  [NSBOX];
    logic [7:0]     lane_out [NSBOX];

    assign both_valid = st_valid & kw_valid;

    // On contention, only the side that was not served last sees ready.
    always_comb begin
        st_ready = 1'b0;
        kw_ready = 1'b0;
        if (state_q == StIdle) begin
            st_ready = !both_valid || (last_grant_q == GNT_KW);
            kw_ready = !both_valid || (last_grant_q == GNT_ST);
        end
    end

    assign st_acc = st_valid & st_ready;
    assign kw_acc = kw_valid & kw_ready;
    assign busy   = (state_q != StIdle);

    // Unused lanes are held at zero so the S-box logic does not toggle.
    always_comb begin
        for (int j = 0; j < NSBOX; j++) begin
            lane_in[j] = 8'h00;
            if (state_q == StSubSt) begin
                lane_in[j] = st_buf_q[(int'(cnt_q) * NSBOX + j) * 8 +: 8];
            end else if (state_q == StSubKw && j < 4) begin
                lane_in[j] = kw_buf_q[(j % 4) * 8 +: 8];
            end
        end
    end

    for (genvar j = 0; j < NSBOX; j++) begin : g_lane
        aes_sub_bytes u_sbox (
            .din  (lane_in[j]),
            .dout (lane_out[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            last_grant_q <= GNT_ST;
            st_buf_q     <= '0;
            kw_buf_q     <= '0;
            st_out       <= '0;
            kw_out       <= '0;
            st_done      <= 1'b0;
            kw_done      <= 1'b0;
        end else begin
            st_done <= 1'b0;
            kw_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (st_acc) begin
                        st_buf_q     <= st_in;
                        last_grant_q <= GNT_ST;
                        cnt_q        <= '0;
                        state_q      <= StSubSt;
                    end else if (kw_acc) begin
                        kw_buf_q     <= kw_in;
                        last_grant_q <= GNT_KW;
                        state_q      <= StSubKw;
                    end
                end
                StSubSt: begin
                    for (int j = 0; j < NSBOX; j++) begin
                        st_out[(int'(cnt_q) * NSBOX + j) * 8 +: 8] <= lane_out[j];
                    end
                    if (cnt_q == CW'(NB - 1)) begin
                        cnt_q   <= '0;
                        st_done <= 1'b1;
                        state_q <= StDoneSt;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StSubKw: begin
                    kw_out  <= {lane_out[3], lane_out[2], lane_out[1], lane_out[0]};
                    kw_done <= 1'b1;
                    state_q <= StDoneKw;
                end
                StDoneSt, StDoneKw: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Self-checking bench for aes_sbox_sched: directed vectors, randomised
// requests and a contention run, checked against a table-based S-box model.
module tb_aes_sbox_sched;

    logic         clk;
    logic         rst_n;
    logic         st_valid;
    logic [127:0] st_in;
    logic         st_ready;
    logic         st_done;
    logic [127:0] st_out;
    logic         kw_valid;
    logic [31:0]  kw_in;
    logic         kw_ready;
    logic         kw_done;
    logic [31:0]  kw_out;
    logic         busy;

    // Shared stimulus for the wider-bank instances
    logic         p_valid;
    logic [127:0] p_in;
    logic         st_ready8, st_done8, kw_ready8, kw_done8, busy8;
    logic [127:0] st_out8;
    logic [31:0]  kw_out8;
    logic         st_ready16, st_done16, kw_ready16, kw_done16, busy16;
    logic [127:0] st_out16;
    logic [31:0]  kw_out16;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sbox_tab [256];

    localparam logic [127:0] V1   = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] V1_S = 128'h76ABD7FE2B670130C56F6BF27B777C63;

    aes_sbox_sched #(.NSBOX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_in(st_in), .st_ready(st_ready),
        .st_done(st_done), .st_out(st_out),
        .kw_valid(kw_valid), .kw_in(kw_in), .kw_ready(kw_ready),
        .kw_done(kw_done), .kw_out(kw_out),
        .busy(busy)
    );

    aes_sbox_sched #(.NSBOX(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .st_valid(p_valid), .st_in(p_in), .st_ready(st_ready8),
        .st_done(st_done8), .st_out(st_out8),
        .kw_valid(1'b0), .kw_in(32'h0), .kw_ready(kw_ready8),
        .kw_done(kw_done8), .kw_out(kw_out8),
        .busy(busy8)
    );

    aes_sbox_sched #(.NSBOX(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .st_valid(p_valid), .st_in(p_in), .st_ready(st_ready16),
        .st_done(st_done16), .st_out(st_out16),
        .kw_valid(1'b0), .kw_in(32'h0), .kw_ready(kw_ready16),
        .kw_done(kw_done16), .kw_out(kw_out16),
        .busy(busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: brute-force field inverse plus the bitwise affine rule
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] acc;
        acc = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) acc = acc ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (acc[i]) acc = acc ^ (16'h011b << (i - 8));
        return acc[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                       ^ inv[(i + 7) % 8] ^ c[i];
            end
            sbox_tab[x] = s;
        end
    endtask

    function automatic logic [127:0] ref_state(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_tab[v[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox_tab[v[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // State request on the NSBOX=4 instance; done expected 5 cycles after accept
    task automatic do_state(input logic [127:0] v);
        logic [31:0] kw_before;
        int k;
        kw_before = kw_out;
        st_valid = 1'b1;
        st_in    = v;
        #1;
        check("st_ready_idle", 128'(st_ready), 128'd1);
        @(posedge clk); #1;
        st_valid = 1'b0;
        st_in    = '1;
        check("busy_sub", 128'(busy), 128'd1);
        k = 1;
        while (st_done !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("st_done_lat", 128'(k), 128'd5);
        check("st_out", st_out, ref_state(v));
        check("kw_out_hold", 128'(kw_out), 128'(kw_before));
        check("busy_done", 128'(busy), 128'd1);
        st_valid = 1'b1;
        #1;
        check("st_ready_done", 128'(st_ready), 128'd0);
        st_valid = 1'b0;
        @(posedge clk); #1;
        check("st_done_pulse", 128'(st_done), 128'd0);
        check("busy_idle", 128'(busy), 128'd0);
    endtask

    // Key-word request; done expected 2 cycles after accept
    task automatic do_kw(input logic [31:0] v);
        logic [127:0] st_before;
        int k;
        st_before = st_out;
        kw_valid = 1'b1;
        kw_in    = v;
        #1;
        check("kw_ready_idle", 128'(kw_ready), 128'd1);
        @(posedge clk); #1;
        kw_valid = 1'b0;
        kw_in    = '1;
        k = 1;
        while (kw_done !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("kw_done_lat", 128'(k), 128'd2);
        check("kw_out", 128'(kw_out), 128'(ref_word(v)));
        check("st_out_hold", st_out, st_before);
        @(posedge clk); #1;
        check("kw_done_pulse", 128'(kw_done), 128'd0);
        check("busy_idle_kw", 128'(busy), 128'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [127:0] st_cap, out8, out16;
        logic [31:0]  kw_cap;
        logic         acc_st, acc_kw;
        int           last_done, ndone, d8, d16;

        rst_n    = 1'b0;
        st_valid = 1'b0;
        kw_valid = 1'b0;
        st_in    = '0;
        kw_in    = '0;
        p_valid  = 1'b0;
        p_in     = '0;
        build_sbox();
        #2;
        check("rst_st_out", st_out, 128'd0);
        check("rst_kw_out", 128'(kw_out), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_dones", 128'({st_done, kw_done}), 128'd0);
        check("rst_readies", 128'({st_ready, kw_ready}), 128'd3);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known vectors
        do_state(V1);
        check("st_out_vec", st_out, V1_S);
        do_kw(32'hCF4F3C09);
        check("kw_out_vec", 128'(kw_out), 128'h8A84EB01);

        // Random mix of single requests
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) == 1) do_state(rand128());
            else do_kw($urandom());
        end

        // Contention: both valid continuously, expect KW,ST,KW,ST,... with no idle gaps
        apply_reset();
        st_valid  = 1'b1;
        kw_valid  = 1'b1;
        st_in     = rand128();
        kw_in     = $urandom();
        st_cap    = '0;
        kw_cap    = '0;
        last_done = -1;
        ndone     = 0;
        #1;
        for (int cyc = 0; cyc < 80 && ndone < 6; cyc++) begin
            if (st_done) begin
                check("arb_order_st", 128'(ndone % 2), 128'd1);
                check("arb_st_out", st_out, ref_state(st_cap));
                check("arb_st_gap", 128'(cyc - last_done), 128'd6);
                last_done = cyc;
                ndone++;
            end
            if (kw_done) begin
                check("arb_order_kw", 128'(ndone % 2), 128'd0);
                check("arb_kw_out", 128'(kw_out), 128'(ref_word(kw_cap)));
                check("arb_kw_gap", 128'(cyc - last_done), 128'd3);
                last_done = cyc;
                ndone++;
            end
            acc_st = st_valid && st_ready;
            acc_kw = kw_valid && kw_ready;
            if (acc_st) st_cap = st_in;
            if (acc_kw) kw_cap = kw_in;
            @(posedge clk); #1;
            if (acc_st) st_in = rand128();
            if (acc_kw) kw_in = $urandom();
            #1;
        end
        check("arb_count", 128'(ndone), 128'd6);
        st_valid = 1'b0;
        kw_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Reset during beat 2 of a state request
        st_valid = 1'b1;
        st_in    = rand128();
        #1;
        @(posedge clk); #1;
        st_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_st_out", st_out, 128'd0);
        check("midrst_busy", 128'(busy), 128'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("midrst_no_done", 128'(st_done), 128'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_idle", 128'(busy), 128'd0);
        do_state(V1);
        check("midrst_recover", st_out, V1_S);

        // Wider banks: same vector, shorter latency
        p_valid = 1'b1;
        p_in    = V1;
        #1;
        @(posedge clk); #1;
        p_valid = 1'b0;
        p_in    = '1;
        d8  = 0;
        d16 = 0;
        out8  = '0;
        out16 = '0;
        for (int k = 1; k <= 10; k++) begin
            if (d8 == 0 && st_done8) begin
                d8   = k;
                out8 = st_out8;
            end
            if (d16 == 0 && st_done16) begin
                d16   = k;
                out16 = st_out16;
            end
            @(posedge clk); #1;
        end
        check("nsbox8_lat", 128'(d8), 128'd3);
        check("nsbox16_lat", 128'(d16), 128'd2);
        check("nsbox8_out", out8, V1_S);
        check("nsbox16_out", out16, V1_S);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_sbox_sched.md
# aes_sbox_sched

Time-multiplexes a bank of `aes_sub_bytes` S-box instances between the AES round datapath (full-state SubBytes, 16 bytes) and the key expansion (SubWord, 4 bytes). It sits between the iterative AES round controller and key scheduler. It serialises each state request over several beats and arbitrates round-robin when both requesters compete.

## Interface
Parameters:
- `NSBOX`, 4, number of S-box instances. Legal values are 4, 8 or 16. Beats per state request are `NB = 16/NSBOX`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `st_valid`  in  1  state SubBytes request.
- `st_in`  in  128  state; byte i = bits [8i+7:8i].
- `st_ready`  out  1  state request may be accepted.
- `st_done`  out  1  one-cycle pulse; `st_out` valid.
- `st_out`  out  128  substituted state, held until next state accept.
- `kw_valid`  in  1  key-word SubWord request.
- `kw_in`  in  32  word; byte i = bits [8i+7:8i].
- `kw_ready`  out  1  key-word request may be accepted.
- `kw_done`  out  1  one-cycle pulse; `kw_out` valid.
- `kw_out`  out  32  substituted word, held until next word accept.
- `busy`  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, SUB_ST, SUB_KW, DONE_ST, DONE_KW.
- Readiness:
  - IDLE: `st_ready` = `kw_ready` = 1 unless both valid. In that case only the granted side's ready is 1.
  - All other states: both ready = 0.
- Accept = valid & ready in IDLE. The input is captured into an internal buffer at the accept edge. The requester may change input afterwards.
- Arbitration: 1-bit `last_grant` register, reset value = ST.
  - Both valid in IDLE: grant the side not equal to `last_grant`.
  - A single valid is granted directly.
  - `last_grant` updates on every accept.
- SUB_ST:
  - Beat counter `cnt` runs 0..NB-1.
  - S-box lane j is fed buffer byte `cnt*NSBOX+j`. Its result is written to `st_out` byte `cnt*NSBOX+j` at the end of the cycle.
  - When `cnt == NB-1`, go to DONE_ST.
- SUB_KW: lanes 0..3 are fed word bytes 0..3. Results are written to `kw_out`, then go to DONE_KW. Lanes ≥4 are driven 0.
- DONE_ST / DONE_KW:
  - Assert the matching done for one cycle, then return to IDLE.
  - Ready stays low in DONE. The next accept is possible in the cycle after the done.
- Valid deasserted before accept: no state change. Valid is not required to stay high after accept.
- In IDLE, S-box lanes are driven 0 (no spurious toggling, which matters for power traces).

## Timing
- Reset (async assert, all outputs): FSM=IDLE, `cnt`=0, `last_grant`=ST, `st_out`=0, `kw_out`=0, both done=0, `busy`=0.
  - Ready outputs are combinational: 1 when the corresponding valid is present.
- State request accepted at edge of cycle T:
  - Beats occupy cycles T+1..T+NB.
  - `st_done` is high in cycle T+NB+1.
  - For NSBOX=4, done is in cycle T+5.
- Key-word request accepted in cycle T: processed in T+1, `kw_done` in T+2.
- Throughput: state, one request per NB+2 cycles; word, one per 3 cycles.
- Reset asserted mid-operation: the request in flight is abandoned, no done is issued, and outputs clear immediately.
- Partially written `st_out` bytes are visible during SUB_ST. Consumers sample only on `st_done`.

## Structure
- Package `aes_sched_pkg`: FSM state enum, grant enum {GNT_ST, GNT_KW}, function `beats(nsbox)` returning 16/nsbox.
- Sub-module: `aes_sub_bytes`, instantiated NSBOX times via generate. No other sub-modules.
- Elaboration check: assertion that NSBOX ∈ {4,8,16}.

## Test plan
- **State only, NSBOX=4.** Drive `st_in`=128'h0F0E0D0C0B0A09080706050403020100, accept at T. Expect `st_done` at T+5 with `st_out`=128'h76ABD7FE2B670130C56F6BF27B777C63, and `busy` high T+1..T+5.
- **Word only.** Drive `kw_in`=32'hCF4F3C09. Expect `kw_done` at T+2 with `kw_out`=32'h8A84EB01; `st_out` unchanged.
- **Simultaneous valid after reset.** KW is granted first, then ST. Next simultaneous pair: KW again, since `last_grant` was ST. Check there are no gaps beyond DONE cycles.
- **Reset mid-beat.** Assert `rst_n`=0 at beat 2 of a state request. Expect no `st_done`, `st_out`=0, IDLE after release, and the next request completes normally.
- **Input change after accept.** Change `st_in` to all-ones at T+1. Output must still correspond to the captured value.
- **Parameter sweep NSBOX=8,16.** Same vector as the first scenario. Expect done at T+3 and T+2 respectively, with identical `st_out`.
